io_panel_ctrl: RTL and testbench

//  Front-panel controller between debounced keys/switches, the hex display and the memory controller.

---
 rtl/io_panel_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_io_panel_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/io_panel_ctrl.sv
// io_panel_ctrl: front-panel controller for nibble-wise address/data entry and one memory transaction.
// The operator cycles CLEAR/WRITE/READ, keys in the address and data pages, then issues a
// req/ready/done handshake. A cycle timeout aborts a stuck transaction and raises a sticky err.
module io_panel_ctrl #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SW_N        = 4,
  parameter int unsigned TIMEOUT_CYC = 1023,
  localparam int unsigned PW    = 4 * SW_N,
  localparam int unsigned NA    = (ADDR_W + PW - 1) / PW,
  localparam int unsigned ND    = (DATA_W + PW - 1) / PW,
  localparam int unsigned STG_W = $clog2(NA + ND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_step,
  input  logic [SW_N-1:0]   sw,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mode_out,
  output logic [STG_W-1:0]  stage_out,
  output logic [PW-1:0]     disp_data,
  output logic              io_done,
  output logic              busy,
  output logic              err
);

  // Address/data registers are padded to whole pages; bits above the real width stay zero.
  localparam int unsigned AP     = NA * PW;
  localparam int unsigned DP     = ND * PW;
  localparam int unsigned PG_MAX = (NA > ND) ? NA : ND;
  localparam int unsigned PGW    = (PG_MAX > 1) ? $clog2(PG_MAX) : 1;
  localparam int unsigned TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [AP-1:0] ADDR_MASK = AP'({ADDR_W{1'b1}});
  localparam logic [DP-1:0] DATA_MASK = DP'({DATA_W{1'b1}});

  localparam logic [1:0] MODE_CLEAR = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_SHOW
  } state_t;

  state_t            stateR, stateNext;
  logic [PGW-1:0]    pageR, pageNext;
  logic [1:0]        modeR, modeNext;
  logic [AP-1:0]     addrR, addrNext;
  logic [DP-1:0]     wdataR, wdataNext;
  logic [DP-1:0]     rdataR, rdataNext;
  logic [TW-1:0]     tmrR, tmrNext;
  logic              errR, errNext;
  logic              prevMode, prevStep;
  logic [SW_N-1:0]   prevSw;

  logic              memReqR, memWeR, memClrR, ioDoneR, busyR;
  logic [STG_W-1:0]  stageR;
  logic [PW-1:0]     dispR;
  logic              memReqNext, memWeNext, memClrNext, ioDoneNext, busyNext;
  logic [STG_W-1:0]  stageNext;
  logic [PW-1:0]     dispNext;

  logic              modeEdge, stepRaw, stepEdge, tmrHit, tmo;
  logic [SW_N-1:0]   swEdge;

  // Rising-edge detection; a mode edge masks a simultaneous step edge.
  assign modeEdge = key_mode & ~prevMode;
  assign stepRaw  = key_step & ~prevStep;
  assign stepEdge = stepRaw & ~modeEdge;
  assign swEdge   = sw & ~prevSw;

  // Timeout fires on the last allowed busy cycle unless mem_done arrives in it.
  assign tmrHit = (TIMEOUT_CYC != 0) && (tmrR == TW'(TIMEOUT_CYC - 1));
  assign tmo    = tmrHit && ((stateR == S_ISSUE) || (stateR == S_WAIT && !mem_done));

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR   <= S_IDLE;
      pageR    <= '0;
      modeR    <= MODE_IDLE;
      addrR    <= '0;
      wdataR   <= '0;
      rdataR   <= '0;
      tmrR     <= '0;
      errR     <= 1'b0;
      prevMode <= 1'b0;
      prevStep <= 1'b0;
      prevSw   <= '0;
      memReqR  <= 1'b0;
      memWeR   <= 1'b0;
      memClrR  <= 1'b0;
      ioDoneR  <= 1'b0;
      busyR    <= 1'b0;
      stageR   <= '0;
      dispR    <= '0;
    end else begin
      stateR   <= stateNext;
      pageR    <= pageNext;
      modeR    <= modeNext;
      addrR    <= addrNext;
      wdataR   <= wdataNext;
      rdataR   <= rdataNext;
      tmrR     <= tmrNext;
      errR     <= errNext;
      prevMode <= key_mode;
      prevStep <= key_step;
      prevSw   <= sw;
      memReqR  <= memReqNext;
      memWeR   <= memWeNext;
      memClrR  <= memClrNext;
      ioDoneR  <= ioDoneNext;
      busyR    <= busyNext;
      stageR   <= stageNext;
      dispR    <= dispNext;
    end
  end

  // Next-state, page, mode, timer and error flag.
  always_comb begin
    stateNext = stateR;
    pageNext  = pageR;
    modeNext  = modeR;
    tmrNext   = (stateR == S_ISSUE || stateR == S_WAIT) ? tmrR + TW'(1) : '0;
    errNext   = tmo ? 1'b1 : ((modeEdge | stepRaw) ? 1'b0 : errR);
    case (stateR)
      S_IDLE: begin
        if (modeEdge) begin
          stateNext = S_SEL;
          modeNext  = MODE_CLEAR;
          pageNext  = '0;
        end
      end
      S_SEL: begin
        if (modeEdge) begin
          case (modeR)
            MODE_CLEAR: modeNext = MODE_WRITE;
            MODE_WRITE: modeNext = MODE_READ;
            default:    modeNext = MODE_CLEAR;
          endcase
        end else if (stepEdge) begin
          pageNext  = '0;
          stateNext = (modeR == MODE_CLEAR) ? S_ISSUE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (modeEdge) begin
          stateNext = S_SEL;
          pageNext  = '0;
        end else if (stepEdge) begin
          if (pageR != PGW'(NA - 1)) begin
            pageNext = pageR + PGW'(1);
          end else begin
            pageNext  = '0;
            stateNext = (modeR == MODE_WRITE) ? S_DATA : S_ISSUE;
          end
        end
      end
      S_DATA: begin
        if (modeEdge) begin
          stateNext = S_SEL;
          pageNext  = '0;
        end else if (stepEdge) begin
          if (pageR != PGW'(ND - 1)) begin
            pageNext = pageR + PGW'(1);
          end else begin
            pageNext  = '0;
            stateNext = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (tmo)            stateNext = S_SEL;
        else if (mem_ready) stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          pageNext  = '0;
          stateNext = (modeR == MODE_READ) ? S_SHOW : S_SEL;
        end else if (tmo) begin
          stateNext = S_SEL;
        end
      end
      S_SHOW: begin
        if (modeEdge) begin
          stateNext = S_SEL;
          pageNext  = '0;
        end else if (stepEdge) begin
          if (pageR != PGW'(ND - 1)) begin
            pageNext = pageR + PGW'(1);
          end else begin
            pageNext  = '0;
            stateNext = S_SEL;
          end
        end
      end
      default: begin
        stateNext = S_IDLE;
        modeNext  = MODE_IDLE;
        pageNext  = '0;
      end
    endcase
  end

  // Per-nibble increments on the current page; masking makes partial top nibbles wrap.
  always_comb begin
    addrNext  = addrR;
    wdataNext = wdataR;
    rdataNext = rdataR;
    for (int unsigned p = 0; p < NA; p++) begin
      for (int unsigned i = 0; i < SW_N; i++) begin
        if (stateR == S_ADDR && pageR == PGW'(p) && swEdge[i])
          addrNext[p*PW + 4*i +: 4] = addrR[p*PW + 4*i +: 4] + 4'd1;
      end
    end
    for (int unsigned p = 0; p < ND; p++) begin
      for (int unsigned i = 0; i < SW_N; i++) begin
        if (stateR == S_DATA && pageR == PGW'(p) && swEdge[i])
          wdataNext[p*PW + 4*i +: 4] = wdataR[p*PW + 4*i +: 4] + 4'd1;
      end
    end
    addrNext  = addrNext & ADDR_MASK;
    wdataNext = wdataNext & DATA_MASK;
    if (stateR == S_WAIT && mem_done)
      rdataNext = DP'(mem_rdata);
  end

  // Output values derived from next state so the ports come straight from flops.
  always_comb begin
    busyNext   = (stateNext == S_ISSUE) || (stateNext == S_WAIT);
    memReqNext = (stateNext == S_ISSUE);
    memWeNext  = busyNext && (modeNext == MODE_WRITE);
    memClrNext = busyNext && (modeNext == MODE_CLEAR);
    ioDoneNext = (stateR == S_WAIT) && mem_done;
    stageNext  = '0;
    dispNext   = '0;
    case (stateNext)
      S_ADDR: begin
        stageNext = STG_W'(pageNext) + STG_W'(1);
        for (int unsigned p = 0; p < NA; p++)
          if (pageNext == PGW'(p)) dispNext = addrNext[p*PW +: PW];
      end
      S_DATA: begin
        stageNext = STG_W'(pageNext) + STG_W'(NA + 1);
        for (int unsigned p = 0; p < ND; p++)
          if (pageNext == PGW'(p)) dispNext = wdataNext[p*PW +: PW];
      end
      S_SHOW: begin
        stageNext = STG_W'(pageNext) + STG_W'(NA + 1);
        for (int unsigned p = 0; p < ND; p++)
          if (pageNext == PGW'(p)) dispNext = rdataNext[p*PW +: PW];
      end
      default: ;
    endcase
  end

  assign mem_req   = memReqR;
  assign mem_we    = memWeR;
  assign mem_clr   = memClrR;
  assign mem_addr  = addrR[ADDR_W-1:0];
  assign mem_wdata = wdataR[DATA_W-1:0];
  assign mode_out  = modeR;
  assign stage_out = stageR;
  assign disp_data = dispR;
  assign io_done   = ioDoneR;
  assign busy      = busyR;
  assign err       = errR;

endmodule

// File: tb/tb_io_panel_ctrl.sv
// tb_io_panel_ctrl: directed scenarios for the front-panel controller (TIMEOUT_CYC=8).
module tb_io_panel_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode, key_step;
  logic [3:0]  sw;
  logic        mem_ready, mem_done;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, mem_clr;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mode_out;
  logic [1:0]  stage_out;
  logic [15:0] disp_data;
  logic        io_done, busy, err;

  int nRun  = 0;
  int nFail = 0;

  io_panel_ctrl #(
    .ADDR_W(25), .DATA_W(16), .SW_N(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_step(key_step), .sw(sw),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_clr(mem_clr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mode_out(mode_out), .stage_out(stage_out),
    .disp_data(disp_data), .io_done(io_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressMode();
    key_mode = 1'b1; tick(); key_mode = 1'b0; tick();
  endtask

  task automatic pressStep();
    key_step = 1'b1; tick(); key_step = 1'b0; tick();
  endtask

  task automatic pressSw(input logic [3:0] mask);
    sw = mask; tick(); sw = 4'h0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    nRun++; if (mode_out !== 2'b11) begin nFail++; $display("FAIL reset_mode got %b exp 11", mode_out); end
    nRun++; if (mem_req !== 1'b0) begin nFail++; $display("FAIL reset_req got %b exp 0", mem_req); end
    nRun++; if (disp_data !== 16'h0) begin nFail++; $display("FAIL reset_disp got %h exp 0000", disp_data); end
    nRun++; if (err !== 1'b0 || io_done !== 1'b0) begin nFail++; $display("FAIL reset_err_done got %b%b exp 00", err, io_done); end
    nRun++; if (stage_out !== 2'd0 || mem_addr !== 25'h0) begin nFail++; $display("FAIL reset_stage_addr got %0d %h exp 0 0", stage_out, mem_addr); end
  endtask

  task automatic test_write();
    pressMode(); pressMode();
    nRun++; if (mode_out !== 2'b10) begin nFail++; $display("FAIL wr_mode got %b exp 10", mode_out); end
    pressStep();
    nRun++; if (stage_out !== 2'd1) begin nFail++; $display("FAIL wr_stage1 got %0d exp 1", stage_out); end
    for (int k = 0; k < 3; k++) pressSw(4'b0001);
    pressSw(4'b1000);
    nRun++; if (disp_data !== 16'h1003) begin nFail++; $display("FAIL wr_page0 got %h exp 1003", disp_data); end
    pressStep();
    pressSw(4'b0100); pressSw(4'b0001);
    nRun++; if (disp_data !== 16'h0101 || stage_out !== 2'd2) begin nFail++; $display("FAIL wr_page1 got %h/%0d exp 0101/2", disp_data, stage_out); end
    pressStep();
    for (int k = 0; k < 10; k++) pressSw(4'b0010);
    nRun++; if (disp_data !== 16'h00A0 || stage_out !== 2'd3) begin nFail++; $display("FAIL wr_data got %h/%0d exp 00a0/3", disp_data, stage_out); end
    pressStep();
    nRun++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_clr !== 1'b0 || busy !== 1'b1) begin nFail++; $display("FAIL wr_issue got req%b we%b clr%b busy%b exp 1101", mem_req, mem_we, mem_clr, busy); end
    nRun++; if (mem_addr !== 25'h1011003 || mem_wdata !== 16'h00A0) begin nFail++; $display("FAIL wr_regs got %h/%h exp 1011003/00a0", mem_addr, mem_wdata); end
    tick();
    nRun++; if (mem_req !== 1'b1) begin nFail++; $display("FAIL wr_req_held got %b exp 1", mem_req); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    nRun++; if (mem_req !== 1'b0 || busy !== 1'b1) begin nFail++; $display("FAIL wr_wait got req%b busy%b exp 01", mem_req, busy); end
    tick();
    mem_done = 1'b1; tick(); mem_done = 1'b0;
    nRun++; if (io_done !== 1'b1 || stage_out !== 2'd0 || busy !== 1'b0 || mode_out !== 2'b10) begin nFail++; $display("FAIL wr_done got done%b stg%0d busy%b mode%b exp 1 0 0 10", io_done, stage_out, busy, mode_out); end
    tick();
    nRun++; if (io_done !== 1'b0) begin nFail++; $display("FAIL wr_done_pulse got %b exp 0", io_done); end
  endtask

  task automatic test_read();
    pressMode();
    nRun++; if (mode_out !== 2'b01) begin nFail++; $display("FAIL rd_mode got %b exp 01", mode_out); end
    pressStep(); pressStep(); pressStep();
    nRun++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'h1011003) begin nFail++; $display("FAIL rd_issue got req%b we%b %h exp 1 0 1011003", mem_req, mem_we, mem_addr); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    nRun++; if (mem_req !== 1'b0) begin nFail++; $display("FAIL rd_accept got %b exp 0", mem_req); end
    mem_done = 1'b1; mem_rdata = 16'hBEEF; tick(); mem_done = 1'b0; mem_rdata = 16'h0;
    nRun++; if (disp_data !== 16'hBEEF || stage_out !== 2'd3 || io_done !== 1'b1) begin nFail++; $display("FAIL rd_show got %h/%0d/%b exp beef/3/1", disp_data, stage_out, io_done); end
    pressStep();
    nRun++; if (stage_out !== 2'd0 || mode_out !== 2'b01 || disp_data !== 16'h0) begin nFail++; $display("FAIL rd_return got %0d/%b/%h exp 0/01/0000", stage_out, mode_out, disp_data); end
  endtask

  task automatic test_wrap();
    pressMode(); pressMode();
    pressStep();
    for (int k = 0; k < 12; k++) pressSw(4'b0001);
    nRun++; if (disp_data !== 16'h100F) begin nFail++; $display("FAIL wrap_pre got %h exp 100f", disp_data); end
    pressSw(4'b0001);
    nRun++; if (disp_data !== 16'h1000) begin nFail++; $display("FAIL wrap_nibble got %h exp 1000", disp_data); end
    pressSw(4'b0011);
    nRun++; if (disp_data !== 16'h1011) begin nFail++; $display("FAIL wrap_simul got %h exp 1011", disp_data); end
    pressStep();
    pressSw(4'b0100);
    nRun++; if (disp_data !== 16'h0001) begin nFail++; $display("FAIL wrap_bit24 got %h exp 0001", disp_data); end
    pressSw(4'b1000);
    nRun++; if (disp_data !== 16'h0001) begin nFail++; $display("FAIL wrap_nobits got %h exp 0001", disp_data); end
    pressMode();
    nRun++; if (stage_out !== 2'd0 || mode_out !== 2'b10 || disp_data !== 16'h0) begin nFail++; $display("FAIL wrap_abort got %0d/%b/%h exp 0/10/0000", stage_out, mode_out, disp_data); end
    nRun++; if (mem_addr !== 25'h0011011) begin nFail++; $display("FAIL wrap_addr got %h exp 0011011", mem_addr); end
  endtask

  task automatic test_timeout();
    pressMode();
    pressStep(); pressStep(); pressStep();
    for (int k = 0; k < 6; k++) begin
      nRun++; if (mem_req !== 1'b1 || io_done !== 1'b0) begin nFail++; $display("FAIL tmo_hold%0d got req%b done%b exp 1 0", k, mem_req, io_done); end
      tick();
    end
    nRun++; if (mem_req !== 1'b1 || err !== 1'b0) begin nFail++; $display("FAIL tmo_last got req%b err%b exp 1 0", mem_req, err); end
    tick();
    nRun++; if (mem_req !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || stage_out !== 2'd0 || io_done !== 1'b0) begin nFail++; $display("FAIL tmo_abort got req%b err%b busy%b stg%0d done%b exp 0 1 0 0 0", mem_req, err, busy, stage_out, io_done); end
    tick();
    nRun++; if (err !== 1'b1 || io_done !== 1'b0 || mode_out !== 2'b01) begin nFail++; $display("FAIL tmo_sticky got err%b done%b mode%b exp 1 0 01", err, io_done, mode_out); end
    pressStep();
    nRun++; if (err !== 1'b0 || stage_out !== 2'd1) begin nFail++; $display("FAIL tmo_clear got err%b stg%0d exp 0 1", err, stage_out); end
    pressMode();
  endtask

  task automatic test_corners();
    key_mode = 1'b1; key_step = 1'b1; tick(); key_mode = 1'b0; key_step = 1'b0; tick();
    nRun++; if (mode_out !== 2'b00 || stage_out !== 2'd0 || mem_req !== 1'b0) begin nFail++; $display("FAIL both_keys got mode%b stg%0d req%b exp 00 0 0", mode_out, stage_out, mem_req); end
    pressStep();
    nRun++; if (mem_req !== 1'b1 || mem_clr !== 1'b1 || mem_we !== 1'b0) begin nFail++; $display("FAIL clr_issue got req%b clr%b we%b exp 1 1 0", mem_req, mem_clr, mem_we); end
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    nRun++; if (busy !== 1'b1 || mem_req !== 1'b0) begin nFail++; $display("FAIL clr_wait got busy%b req%b exp 1 0", busy, mem_req); end
    rst = 1'b1; tick();
    nRun++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_clr !== 1'b0 || mode_out !== 2'b11) begin nFail++; $display("FAIL rst_wait got req%b busy%b clr%b mode%b exp 0 0 0 11", mem_req, busy, mem_clr, mode_out); end
    nRun++; if (mem_addr !== 25'h0 || mem_wdata !== 16'h0 || disp_data !== 16'h0 || stage_out !== 2'd0 || err !== 1'b0 || io_done !== 1'b0) begin nFail++; $display("FAIL rst_regs got %h %h %h %0d %b %b exp all 0", mem_addr, mem_wdata, disp_data, stage_out, err, io_done); end
    rst = 1'b0; tick();
    pressMode(); pressStep();
    nRun++; if (mem_req !== 1'b1) begin nFail++; $display("FAIL clr_reissue got %b exp 1", mem_req); end
    rst = 1'b1; tick(); rst = 1'b0;
    nRun++; if (mem_req !== 1'b0 || mode_out !== 2'b11) begin nFail++; $display("FAIL rst_issue got req%b mode%b exp 0 11", mem_req, mode_out); end
    tick();
  endtask

  initial begin
    rst = 1'b1; key_mode = 1'b0; key_step = 1'b0; sw = 4'h0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_timeout();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
